// File: rtl/fetch_seq_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer (master)
// and the instruction memory (slave).
interface fetch_seq_ctrl_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err
    );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Multi-cycle fetch/execute sequencer: owns the architectural PC, runs the imem
// handshake, hands instructions to decode and traps on halt or fetch faults.
module fetch_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [15:0] TIMEOUT  = 16'd255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    fetch_seq_ctrl_if.master imem,
    output logic [31:0]      inst_out,
    output logic             inst_valid,
    input  logic             exec_done,
    input  logic [31:0]      pc_next,
    input  logic             halt_req,
    output logic [31:0]      pc_out,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [63:0]      instret
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_REQ  = 3'd1,
        FETCH_WAIT = 3'd2,
        EXEC       = 3'd3,
        HALT       = 3'd4,
        FAULT      = 3'd5
    } state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_BUSERR   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return (pc_lsb != 2'b00);
    endfunction

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  cause_q, cause_d;
    logic [63:0] instret_q, instret_d;
    logic        req_valid_q;
    logic        inst_valid_q;
    logic        halted_q;
    logic        fault_q;

    // Architectural state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0000_0000;
            cnt_q     <= 16'd0;
            cause_q   <= CAUSE_NONE;
            instret_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        instret_d = instret_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = FETCH_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH_REQ: begin
                // A misaligned PC traps before any request is raised.
                if (is_misaligned(pc_q[1:0])) begin
                    state_d = FAULT;
                    cause_d = CAUSE_MISALIGN;
                end else if (req_valid_q && imem.imem_req_ready) begin
                    state_d = FETCH_WAIT;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // A response arriving on the final allowed cycle still wins.
                if (imem.imem_rsp_valid && !imem.imem_rsp_err) begin
                    inst_d  = imem.imem_rsp_data;
                    state_d = EXEC;
                end else if (imem.imem_rsp_valid && imem.imem_rsp_err) begin
                    state_d = FAULT;
                    cause_d = CAUSE_BUSERR;
                end else if (cnt_q == (TIMEOUT - 16'd1)) begin
                    state_d = FAULT;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    state_d = FETCH_WAIT;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    instret_d = instret_q + 64'd1;
                    if (halt_req) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = pc_next;
                        state_d = en ? FETCH_REQ : IDLE;
                    end
                end else begin
                    state_d = EXEC;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            req_valid_q  <= (state_d == FETCH_REQ) && !is_misaligned(pc_d[1:0]);
            inst_valid_q <= (state_d == EXEC);
            halted_q     <= (state_d == HALT);
            fault_q      <= (state_d == FAULT);
        end
    end

    assign imem.imem_req_valid = req_valid_q;
    assign imem.imem_req_addr  = pc_q;
    assign inst_out            = inst_q;
    assign inst_valid          = inst_valid_q;
    assign pc_out              = pc_q;
    assign halted              = halted_q;
    assign fault               = fault_q;
    assign fault_cause         = cause_q;
    assign instret             = instret_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Scoreboard bench for fetch_seq_ctrl: expected fetch addresses and
// instruction words are queued as stimulus is driven and popped on output.
module tb_fetch_seq_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        exec_done;
    logic [31:0] pc_next;
    logic        halt_req;
    logic [31:0] pc_out;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [63:0] instret;

    fetch_seq_ctrl_if imem_if ();

    fetch_seq_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(16'd4)) dut (
        .clk(clk), .rst(rst), .en(en), .imem(imem_if),
        .inst_out(inst_out), .inst_valid(inst_valid), .exec_done(exec_done),
        .pc_next(pc_next), .halt_req(halt_req), .pc_out(pc_out),
        .halted(halted), .fault(fault), .fault_cause(fault_cause), .instret(instret)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_inst[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; exec_done = 1'b0; pc_next = 32'h0; halt_req = 1'b0;
        imem_if.imem_req_ready = 1'b0; imem_if.imem_rsp_valid = 1'b0;
        imem_if.imem_rsp_data = 32'h0; imem_if.imem_rsp_err = 1'b0;
        exp_addr.delete(); exp_inst.delete();
        tick(); tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a request, accepts it, returns a one-cycle response.
    task automatic fetch_inst(input logic [31:0] data, output logic ok, output logic [31:0] addr_seen);
        int n = 0;
        while (imem_if.imem_req_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        ok = (imem_if.imem_req_valid === 1'b1);
        addr_seen = imem_if.imem_req_addr;
        imem_if.imem_req_ready = 1'b1;
        tick();
        imem_if.imem_req_ready = 1'b0;
        imem_if.imem_rsp_valid = 1'b1;
        imem_if.imem_rsp_data  = data;
        exp_inst.push_back(data);
        tick();
        imem_if.imem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc_out !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_out, RST_PC); end
        checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", inst_out); end
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
        checks++; if (fault_cause !== 2'd0) begin errors++; $display("FAIL reset_cause: got %0d expected 0", fault_cause); end
        checks++; if ({imem_if.imem_req_valid, inst_valid, halted, fault} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {imem_if.imem_req_valid, inst_valid, halted, fault}); end
        tick();
        checks++; if (imem_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b expected 0", imem_if.imem_req_valid); end
    endtask

    task automatic test_basic_fetch();
        logic ok; logic [31:0] a; logic [31:0] e;
        do_reset();
        exp_addr.push_back(RST_PC);
        en = 1'b1;
        fetch_inst(32'h0000_0013, ok, a);
        checks++; if (!ok) begin errors++; $display("FAIL basic_req_timeout: got no request expected one"); end
        e = exp_addr.pop_front();
        checks++; if (a !== e) begin errors++; $display("FAIL basic_addr: got %h expected %h", a, e); end
        e = exp_inst.pop_front();
        checks++; if (inst_valid !== 1'b1 || inst_out !== e) begin
            errors++; $display("FAIL basic_inst: got v=%b %h expected v=1 %h", inst_valid, inst_out, e); end
        exec_done = 1'b1; pc_next = 32'h8000_0004;
        exp_addr.push_back(32'h8000_0004);
        tick();
        exec_done = 1'b0;
        checks++; if (pc_out !== 32'h8000_0004) begin errors++; $display("FAIL basic_pc: got %h expected 80000004", pc_out); end
        checks++; if (instret !== 64'd1) begin errors++; $display("FAIL basic_instret: got %0d expected 1", instret); end
        e = exp_addr.pop_front();
        checks++; if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_req_addr !== e) begin
            errors++; $display("FAIL basic_second_req: got v=%b %h expected v=1 %h", imem_if.imem_req_valid, imem_if.imem_req_addr, e); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_inst_drop: got %b expected 0", inst_valid); end
    endtask

    task automatic test_ready_stall();
        logic [31:0] e;
        do_reset();
        en = 1'b1;
        exp_addr.push_back(RST_PC);
        tick();
        e = exp_addr.pop_front();
        for (int i = 0; i < 6; i++) begin
            checks++; if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_req_addr !== e) begin
                errors++; $display("FAIL stall_cycle%0d: got v=%b %h expected v=1 %h", i, imem_if.imem_req_valid, imem_if.imem_req_addr, e); end
            if (i < 5) tick();
        end
        imem_if.imem_req_ready = 1'b1;
        tick();
        imem_if.imem_req_ready = 1'b0;
        checks++; if (imem_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_handshake: got %b expected 0", imem_if.imem_req_valid); end
        imem_if.imem_rsp_valid = 1'b1; imem_if.imem_rsp_data = 32'h0010_0093;
        exp_inst.push_back(32'h0010_0093);
        tick();
        imem_if.imem_rsp_valid = 1'b0;
        e = exp_inst.pop_front();
        checks++; if (inst_valid !== 1'b1 || inst_out !== e) begin
            errors++; $display("FAIL stall_inst: got v=%b %h expected v=1 %h", inst_valid, inst_out, e); end
    endtask

    task automatic test_misaligned();
        logic ok; logic [31:0] a; logic seen;
        do_reset();
        en = 1'b1;
        fetch_inst(32'h0000_0013, ok, a);
        void'(exp_inst.pop_front());
        checks++; if (!ok) begin errors++; $display("FAIL mis_req_timeout: got no request expected one"); end
        exec_done = 1'b1; pc_next = 32'h8000_0102;
        tick();
        exec_done = 1'b0;
        seen = imem_if.imem_req_valid;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | imem_if.imem_req_valid;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %b expected 0", seen); end
        checks++; if (fault !== 1'b1 || fault_cause !== 2'd1) begin
            errors++; $display("FAIL mis_fault: got f=%b c=%0d expected f=1 c=1", fault, fault_cause); end
        checks++; if (pc_out !== 32'h8000_0102) begin errors++; $display("FAIL mis_pc: got %h expected 80000102", pc_out); end
        checks++; if (inst_valid !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL mis_flags: got iv=%b h=%b expected 0 0", inst_valid, halted); end
    endtask

    task automatic test_bus_error();
        do_reset();
        en = 1'b1;
        tick();
        imem_if.imem_req_ready = 1'b1;
        tick();
        imem_if.imem_req_ready = 1'b0;
        imem_if.imem_rsp_valid = 1'b1; imem_if.imem_rsp_err = 1'b1; imem_if.imem_rsp_data = 32'h1234_5678;
        tick();
        imem_if.imem_rsp_valid = 1'b0; imem_if.imem_rsp_err = 1'b0;
        checks++; if (fault !== 1'b1 || fault_cause !== 2'd2) begin
            errors++; $display("FAIL buserr_fault: got f=%b c=%0d expected f=1 c=2", fault, fault_cause); end
        checks++; if (inst_valid !== 1'b0 || inst_out !== 32'h0 || pc_out !== RST_PC) begin
            errors++; $display("FAIL buserr_state: got iv=%b inst=%h pc=%h expected 0 0 %h", inst_valid, inst_out, pc_out, RST_PC); end
    endtask

    task automatic test_timeout(input logic late_rsp);
        logic [31:0] e;
        do_reset();
        en = 1'b1;
        tick();
        imem_if.imem_req_ready = 1'b1;
        tick();
        imem_if.imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL timeout_early(%0b): got %b expected 0", late_rsp, fault); end
        if (late_rsp) begin
            imem_if.imem_rsp_valid = 1'b1; imem_if.imem_rsp_data = 32'hABCD_0013;
            exp_inst.push_back(32'hABCD_0013);
        end
        tick();
        imem_if.imem_rsp_valid = 1'b0;
        if (late_rsp) begin
            e = exp_inst.pop_front();
            checks++; if (fault !== 1'b0 || inst_valid !== 1'b1 || inst_out !== e) begin
                errors++; $display("FAIL timeout_race: got f=%b iv=%b %h expected f=0 iv=1 %h", fault, inst_valid, inst_out, e); end
        end else begin
            checks++; if (fault !== 1'b1 || fault_cause !== 2'd3) begin
                errors++; $display("FAIL timeout_fault: got f=%b c=%0d expected f=1 c=3", fault, fault_cause); end
        end
    endtask

    task automatic test_halt();
        logic ok; logic [31:0] a; logic [31:0] e; logic seen;
        do_reset();
        en = 1'b1;
        fetch_inst(32'h0000_0013, ok, a);
        void'(exp_inst.pop_front());
        exec_done = 1'b1; pc_next = 32'h8000_0010;
        exp_addr.push_back(32'h8000_0010);
        tick();
        exec_done = 1'b0;
        fetch_inst(32'h0010_0073, ok, a);
        e = exp_addr.pop_front();
        checks++; if (!ok || a !== e) begin errors++; $display("FAIL halt_addr: got ok=%b %h expected ok=1 %h", ok, a, e); end
        e = exp_inst.pop_front();
        checks++; if (inst_valid !== 1'b1 || inst_out !== e) begin
            errors++; $display("FAIL halt_inst: got v=%b %h expected v=1 %h", inst_valid, inst_out, e); end
        exec_done = 1'b1; halt_req = 1'b1; pc_next = 32'h8000_0014;
        tick();
        halt_req = 1'b0;
        checks++; if (halted !== 1'b1 || fault !== 1'b0) begin
            errors++; $display("FAIL halt_flags: got h=%b f=%b expected h=1 f=0", halted, fault); end
        checks++; if (pc_out !== 32'h8000_0010) begin errors++; $display("FAIL halt_pc: got %h expected 80000010", pc_out); end
        seen = imem_if.imem_req_valid | inst_valid;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | imem_if.imem_req_valid | inst_valid;
        end
        exec_done = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL halt_quiet: got %b expected 0", seen); end
        checks++; if (instret !== 64'd2) begin errors++; $display("FAIL halt_instret: got %0d expected 2", instret); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", halted); end
    endtask

    task automatic test_reset_mid();
        logic ok; logic [31:0] a;
        do_reset();
        en = 1'b1;
        fetch_inst(32'h0000_0013, ok, a);
        exec_done = 1'b1; pc_next = 32'h8000_0040;
        tick();
        exec_done = 1'b0;
        imem_if.imem_req_ready = 1'b1;
        tick();
        imem_if.imem_req_ready = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++; if (pc_out !== RST_PC || imem_if.imem_req_valid !== 1'b0 || instret !== 64'd0) begin
            errors++; $display("FAIL midrst_async: got pc=%h rv=%b ir=%0d expected %h 0 0", pc_out, imem_if.imem_req_valid, instret, RST_PC); end
        tick();
        rst = 1'b0; en = 1'b0;
        imem_if.imem_rsp_valid = 1'b1; imem_if.imem_rsp_data = 32'hDEAD_0013;
        tick();
        imem_if.imem_rsp_valid = 1'b0;
        tick();
        checks++; if (inst_valid !== 1'b0 || inst_out !== 32'h0) begin
            errors++; $display("FAIL midrst_rsp_ignored: got iv=%b %h expected 0 0", inst_valid, inst_out); end
        checks++; if (pc_out !== RST_PC || fault !== 1'b0 || imem_if.imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_idle: got pc=%h f=%b rv=%b expected %h 0 0", pc_out, fault, imem_if.imem_req_valid, RST_PC); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_ready_stall();
        test_misaligned();
        test_bus_error();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
